// File: rtl/nes_mem_pkg.sv
// Shared types and constants for the NES shared-memory initiator.
// Covers FSM and grant encodings, address-region tags and the hold-counter load helper.
package nes_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_PPU = 1'b1
    } grant_e;

    localparam int ADDR_W = 22;

    // Upper address bits that tag each region of the 22-bit space
    localparam logic [0:0] REGION_PRG      = 1'b0;
    localparam logic [1:0] REGION_CHR      = 2'b10;
    localparam logic [3:0] REGION_VRAM     = 4'b1100;
    localparam logic [3:0] REGION_CPU_RAM  = 4'b1110;
    localparam logic [3:0] REGION_CART_RAM = 4'b1111;

    // The hold counter counts HOLD-1 down to 0, so a strobe lasts exactly HOLD cycles
    function automatic logic [3:0] hold_load(input int hold);
        return 4'(hold - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: picks the CPU or the PPU and returns a one-hot grant.
// gnt[0] is the CPU and gnt[1] is the PPU. Under contention, the side not granted last wins.
module rr_arb2
    import nes_mem_pkg::*;
(
    input  logic       cpu_req,
    input  logic       ppu_req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Grant selection
    always_comb begin
        gnt = 2'b00;
        if (cpu_req && ppu_req) begin
            if (last_grant == GNT_PPU) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (cpu_req) begin
            gnt = 2'b01;
        end else if (ppu_req) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/nes_mem_initiator.sv
// Bus master for the NES shared memory. It arbitrates CPU and PPU requests and serialises each grant onto the memory bus.
// Results are returned with a one-cycle ack pulse. No grant is made until load_done is high.
module nes_mem_initiator
    import nes_mem_pkg::*;
#(
    parameter int RD_HOLD = 2,
    parameter int WR_HOLD = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_req,
    input  logic [21:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_rdata,
    output logic [21:0] mem_addr,
    output logic        mem_rd_cpu,
    output logic        mem_rd_ppu,
    output logic        mem_wr,
    output logic [7:0]  mem_d,
    input  logic [7:0]  mem_q_cpu,
    input  logic [7:0]  mem_q_ppu
);

    state_e      state_r,      state_s;
    grant_e      last_grant_r, last_grant_s;
    logic [3:0]  hold_cnt_r,   hold_cnt_s;
    logic [21:0] mem_addr_r,   mem_addr_s;
    logic [7:0]  mem_d_r,      mem_d_s;
    logic        rd_cpu_r,     rd_cpu_s;
    logic        rd_ppu_r,     rd_ppu_s;
    logic        wr_r,         wr_s;
    logic        cpu_ack_r,    cpu_ack_s;
    logic        ppu_ack_r,    ppu_ack_s;
    logic [7:0]  cpu_rdata_r,  cpu_rdata_s;
    logic [7:0]  ppu_rdata_r,  ppu_rdata_s;
    logic [1:0]  gnt_s;

    rr_arb2 u_arb (
        .cpu_req    (cpu_req),
        .ppu_req    (ppu_req),
        .last_grant (last_grant_r),
        .gnt        (gnt_s)
    );

    // Next-state and next-output logic; last_grant_r also names the side owning the transaction in flight
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        hold_cnt_s   = hold_cnt_r;
        mem_addr_s   = mem_addr_r;
        mem_d_s      = mem_d_r;
        rd_cpu_s     = rd_cpu_r;
        rd_ppu_s     = rd_ppu_r;
        wr_s         = wr_r;
        cpu_ack_s    = 1'b0;
        ppu_ack_s    = 1'b0;
        cpu_rdata_s  = cpu_rdata_r;
        ppu_rdata_s  = ppu_rdata_r;
        case (state_r)
            IDLE: begin
                if (load_done && gnt_s[0]) begin
                    last_grant_s = GNT_CPU;
                    mem_addr_s   = cpu_addr;
                    if (cpu_we) begin
                        mem_d_s    = cpu_wdata;
                        wr_s       = 1'b1;
                        hold_cnt_s = hold_load(WR_HOLD);
                        state_s    = WR;
                    end else begin
                        mem_d_s    = 8'h00;
                        rd_cpu_s   = 1'b1;
                        hold_cnt_s = hold_load(RD_HOLD);
                        state_s    = RD;
                    end
                end else if (load_done && gnt_s[1]) begin
                    last_grant_s = GNT_PPU;
                    mem_addr_s   = ppu_addr;
                    mem_d_s      = 8'h00;
                    rd_ppu_s     = 1'b1;
                    hold_cnt_s   = hold_load(RD_HOLD);
                    state_s      = RD;
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (hold_cnt_r == 4'd0) begin
                    rd_cpu_s = 1'b0;
                    rd_ppu_s = 1'b0;
                    state_s  = CAP;
                end else begin
                    hold_cnt_s = hold_cnt_r - 4'd1;
                end
            end
            CAP: begin
                if (last_grant_r == GNT_CPU) begin
                    cpu_rdata_s = mem_q_cpu;
                    cpu_ack_s   = 1'b1;
                end else begin
                    ppu_rdata_s = mem_q_ppu;
                    ppu_ack_s   = 1'b1;
                end
                state_s = DONE;
            end
            WR: begin
                if (hold_cnt_r == 4'd0) begin
                    wr_s      = 1'b0;
                    cpu_ack_s = 1'b1;
                    state_s   = DONE;
                end else begin
                    hold_cnt_s = hold_cnt_r - 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                rd_cpu_s = 1'b0;
                rd_ppu_s = 1'b0;
                wr_s     = 1'b0;
                state_s  = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= GNT_PPU;
            hold_cnt_r   <= 4'd0;
            mem_addr_r   <= 22'd0;
            mem_d_r      <= 8'h00;
            rd_cpu_r     <= 1'b0;
            rd_ppu_r     <= 1'b0;
            wr_r         <= 1'b0;
            cpu_ack_r    <= 1'b0;
            ppu_ack_r    <= 1'b0;
            cpu_rdata_r  <= 8'h00;
            ppu_rdata_r  <= 8'h00;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            hold_cnt_r   <= hold_cnt_s;
            mem_addr_r   <= mem_addr_s;
            mem_d_r      <= mem_d_s;
            rd_cpu_r     <= rd_cpu_s;
            rd_ppu_r     <= rd_ppu_s;
            wr_r         <= wr_s;
            cpu_ack_r    <= cpu_ack_s;
            ppu_ack_r    <= ppu_ack_s;
            cpu_rdata_r  <= cpu_rdata_s;
            ppu_rdata_r  <= ppu_rdata_s;
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_d      = mem_d_r;
    assign mem_rd_cpu = rd_cpu_r;
    assign mem_rd_ppu = rd_ppu_r;
    assign mem_wr     = wr_r;
    assign cpu_ack    = cpu_ack_r;
    assign ppu_ack    = ppu_ack_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign ppu_rdata  = ppu_rdata_r;

endmodule

// File: tb/tb_nes_mem_initiator.sv
// Scoreboard bench for nes_mem_initiator. It pairs a memory-device model with a reference memory, queues and an arbitration rule.
// A second instance built with RD_HOLD=4 and WR_HOLD=3 checks strobe widths and latencies.
module tb_nes_mem_initiator;
    import nes_mem_pkg::*;

    localparam int RDH = 2;
    localparam int WRH = 1;
    localparam int RDH_B = 4;
    localparam int WRH_B = 3;
    localparam int WAIT_MAX = 300;

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clock, reset, load_done;
    logic        cpu_req, cpu_we, cpu_ack, ppu_req, ppu_ack;
    logic [21:0] cpu_addr, ppu_addr, mem_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, ppu_rdata, mem_d, mem_q_cpu, mem_q_ppu;
    logic        mem_rd_cpu, mem_rd_ppu, mem_wr;

    logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_ppu_ack, b_rd_cpu, b_rd_ppu, b_wr;
    logic [21:0] b_mem_addr;
    logic [7:0]  b_cpu_rdata, b_ppu_rdata, b_mem_d, b_q_cpu, b_q_ppu;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    txn_t cpu_q[$];
    txn_t ppu_q[$];
    int   grant_log[$];
    logic [7:0] ref_mem[int];
    logic [7:0] dev_mem[int];
    bit   rand_done;

    nes_mem_initiator #(.RD_HOLD(RDH), .WR_HOLD(WRH)) u_dut (
        .clock(clock), .reset(reset), .load_done(load_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .mem_addr(mem_addr), .mem_rd_cpu(mem_rd_cpu), .mem_rd_ppu(mem_rd_ppu),
        .mem_wr(mem_wr), .mem_d(mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu)
    );

    nes_mem_initiator #(.RD_HOLD(RDH_B), .WR_HOLD(WRH_B)) u_dut_b (
        .clock(clock), .reset(reset), .load_done(1'b1),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(22'h3C0000), .cpu_wdata(8'h11),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ppu_req(1'b0), .ppu_addr(22'h200000), .ppu_ack(b_ppu_ack), .ppu_rdata(b_ppu_rdata),
        .mem_addr(b_mem_addr), .mem_rd_cpu(b_rd_cpu), .mem_rd_ppu(b_rd_ppu),
        .mem_wr(b_wr), .mem_d(b_mem_d), .mem_q_cpu(b_q_cpu), .mem_q_ppu(b_q_ppu)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] default_byte(input logic [21:0] a);
        return a[7:0] ^ {a[21:18], a[11:8]};
    endfunction

    function automatic logic [7:0] ref_read(input logic [21:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return default_byte(a);
    endfunction

    // Memory device: registered read data, writes land on the strobe edge
    always @(posedge clock) begin
        cyc++;
        if (mem_wr) dev_mem[int'(mem_addr)] = mem_d;
        if (mem_rd_cpu) mem_q_cpu <= dev_mem.exists(int'(mem_addr)) ? dev_mem[int'(mem_addr)] : default_byte(mem_addr);
        if (mem_rd_ppu) mem_q_ppu <= dev_mem.exists(int'(mem_addr)) ? dev_mem[int'(mem_addr)] : default_byte(mem_addr);
    end

    // Request levels as seen by the DUT on each edge
    logic e_c, e_p, e_ld;
    always @(posedge clock) begin
        e_c  = cpu_req;
        e_p  = ppu_req;
        e_ld = load_done;
    end

    // Monitor: grant rule, bus contents, strobe widths, acks against the scoreboard
    bit   prev_any = 1'b0;
    int   last_side = 1;
    int   w_cnt = 0;
    bit   w_is_wr = 1'b0;
    int   rise_c = 0;
    int   rise_p = 0;
    always @(negedge clock) begin
        bit   any;
        int   side, exp_side;
        txn_t t;
        if (reset) begin
            prev_any  = 1'b0;
            last_side = 1;
            w_cnt     = 0;
        end else begin
            any = mem_rd_cpu | mem_rd_ppu | mem_wr;
            if (any) chk("strobe_onehot", 32'(mem_rd_cpu) + 32'(mem_rd_ppu) + 32'(mem_wr), 32'd1);
            if (any && !prev_any) begin
                side = mem_rd_ppu ? 1 : 0;
                chk("grant_load_done", 32'(e_ld), 32'd1);
                chk("grant_had_req", 32'(e_c | e_p), 32'd1);
                exp_side = (e_c && e_p) ? (1 - last_side) : (e_c ? 0 : 1);
                chk("grant_side", 32'(side), 32'(exp_side));
                last_side = side;
                grant_log.push_back(side);
                if (side == 0) begin
                    chk("cpu_pending_at_grant", 32'(cpu_q.size() != 0), 32'd1);
                    if (cpu_q.size() != 0) begin
                        t = cpu_q[0];
                        chk("cpu_mem_addr", 32'(mem_addr), 32'(t.addr));
                        chk("cpu_strobe_kind", 32'(mem_wr), 32'(t.we));
                        chk("cpu_mem_d", 32'(mem_d), t.we ? 32'(t.data) : 32'd0);
                    end
                    rise_c = cyc;
                end else begin
                    chk("ppu_pending_at_grant", 32'(ppu_q.size() != 0), 32'd1);
                    if (ppu_q.size() != 0) chk("ppu_mem_addr", 32'(mem_addr), 32'(ppu_q[0].addr));
                    rise_p = cyc;
                end
                w_cnt   = 0;
                w_is_wr = mem_wr;
            end
            if (any) w_cnt++;
            if (!any && prev_any) chk("strobe_width", 32'(w_cnt), w_is_wr ? 32'(WRH) : 32'(RDH));
            prev_any = any;
            if (cpu_ack) begin
                chk("cpu_ack_pending", 32'(cpu_q.size() != 0), 32'd1);
                if (cpu_q.size() != 0) begin
                    t = cpu_q.pop_front();
                    chk("cpu_latency", 32'(cyc - rise_c), t.we ? 32'(WRH) : 32'(RDH + 1));
                    if (!t.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(t.data));
                end
            end
            if (ppu_ack) begin
                chk("ppu_ack_pending", 32'(ppu_q.size() != 0), 32'd1);
                if (ppu_q.size() != 0) begin
                    t = ppu_q.pop_front();
                    chk("ppu_latency", 32'(cyc - rise_p), 32'(RDH + 1));
                    chk("ppu_rdata", 32'(ppu_rdata), 32'(t.data));
                end
            end
        end
    end

    task automatic cpu_issue(input logic we, input logic [21:0] a, input logic [7:0] d);
        txn_t t;
        t.we   = we;
        t.addr = a;
        t.data = we ? d : ref_read(a);
        if (we) ref_mem[int'(a)] = d;
        cpu_q.push_back(t);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    endtask

    task automatic cpu_wait();
        bit got = 1'b0;
        for (int i = 0; i < WAIT_MAX && !got; i++) begin
            @(negedge clock);
            got = cpu_ack;
        end
        chk("cpu_ack_timeout", 32'(got), 32'd1);
        @(posedge clock); #1;
        cpu_req = 1'b0;
    endtask

    task automatic ppu_issue(input logic [21:0] a);
        txn_t t;
        t.we   = 1'b0;
        t.addr = a;
        t.data = ref_read(a);
        ppu_q.push_back(t);
        ppu_addr = a; ppu_req = 1'b1;
    endtask

    task automatic ppu_wait();
        bit got = 1'b0;
        for (int i = 0; i < WAIT_MAX && !got; i++) begin
            @(negedge clock);
            got = ppu_ack;
        end
        chk("ppu_ack_timeout", 32'(got), 32'd1);
        @(posedge clock); #1;
        ppu_req = 1'b0;
    endtask

    task automatic b_txn(input logic we, input int exp_w, input int exp_lat);
        int w = 0, rise = -1, ack = -1;
        b_cpu_we = we; b_cpu_req = 1'b1;
        for (int i = 0; i < 60 && ack < 0; i++) begin
            @(negedge clock);
            if (b_rd_cpu | b_wr) begin
                if (rise < 0) rise = i;
                w++;
            end
            if (b_cpu_ack) ack = i;
        end
        @(posedge clock); #1;
        b_cpu_req = 1'b0;
        chk("b_strobe_width", 32'(w), 32'(exp_w));
        chk("b_latency", 32'(ack - rise + 1), 32'(exp_lat));
        if (!we) chk("b_cpu_rdata", 32'(b_cpu_rdata), 32'h5A);
    endtask

    initial begin
        int quiet;
        int exp_seq[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        reset = 1'b1; load_done = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 22'd0; cpu_wdata = 8'h00;
        ppu_req = 1'b0; ppu_addr = 22'd0;
        mem_q_cpu = 8'h00; mem_q_ppu = 8'h00;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_q_cpu = 8'h5A; b_q_ppu = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 32'({mem_addr, mem_d, mem_rd_cpu, mem_rd_ppu, mem_wr}) | 32'({cpu_ack, ppu_ack, cpu_rdata, ppu_rdata}), 32'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        // No grant while load_done is low
        cpu_issue(1'b0, {REGION_CPU_RAM, 18'h00020}, 8'h00);
        quiet = 0;
        repeat (20) begin
            @(negedge clock);
            quiet += int'(mem_rd_cpu | mem_rd_ppu | mem_wr | cpu_ack | ppu_ack);
        end
        chk("blocked_by_load_done", 32'(quiet), 32'd0);
        @(posedge clock); #1;
        load_done = 1'b1;
        cpu_wait();

        // Write then read back
        cpu_issue(1'b1, 22'h380010, 8'hA5);
        cpu_wait();
        cpu_issue(1'b0, 22'h380010, 8'h00);
        cpu_wait();
        chk("cpu_rdata_held", 32'(cpu_rdata), 32'hA5);

        // PPU read with known contents
        dev_mem[int'(22'h200123)] = 8'h3C;
        ref_mem[int'(22'h200123)] = 8'h3C;
        ppu_issue(22'h200123);
        ppu_wait();
        chk("ppu_rdata_held", 32'(ppu_rdata), 32'h3C);

        // Contention: both sides held high for 4 transactions each
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    cpu_issue(1'(i % 2), {REGION_CPU_RAM, 10'd0, 8'($urandom)}, 8'($urandom));
                    cpu_wait();
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    ppu_issue({REGION_CHR, 12'd0, 8'($urandom)});
                    ppu_wait();
                end
            end
        join
        chk("rr_grant_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("rr_grant_order", 32'(grant_log[k]), 32'(exp_seq[k]));

        // Reset during the second RD cycle of a PPU read
        ppu_issue(22'h200040);
        for (int i = 0; i < WAIT_MAX && !mem_rd_ppu; i++) @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_reset_outputs", 32'({mem_addr, mem_d, mem_rd_cpu, mem_rd_ppu, mem_wr}) | 32'({cpu_ack, ppu_ack, cpu_rdata, ppu_rdata}), 32'd0);
        ppu_q.delete();
        repeat (2) @(negedge clock);
        ppu_issue(22'h200040);
        reset = 1'b0;
        ppu_wait();

        // Randomised traffic with load_done dropouts
        rand_done = 1'b0;
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 30; i++) begin
                            repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                            cpu_issue(1'($urandom), {REGION_CPU_RAM, 10'd0, 4'd0, 4'($urandom)}, 8'($urandom));
                            cpu_wait();
                        end
                    end
                    begin
                        for (int j = 0; j < 30; j++) begin
                            repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                            ppu_issue({REGION_CHR, 12'd0, 8'($urandom)});
                            ppu_wait();
                        end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    repeat ($urandom_range(10, 30)) @(posedge clock);
                    #1; load_done = 1'b0;
                    repeat ($urandom_range(1, 4)) @(posedge clock);
                    #1; load_done = 1'b1;
                end
            end
        join
        repeat (4) @(negedge clock);
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        chk("ppu_queue_drained", 32'(ppu_q.size()), 32'd0);

        // Wider-hold build
        @(posedge clock); #1;
        b_txn(1'b0, RDH_B, RDH_B + 2);
        b_txn(1'b1, WRH_B, WRH_B + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
